localbus_dma: RTL

Word-copy DMA engine acting as a second initiator on the LocalBus, alongside the CPU data port. Given source, destination and word count, it requests the bus, reads each word from the source region and writes it to the destination region, e.g. RAM to VRAM. It drives the same addr / wdata / we / rdata signal set the LocalBus decoder accepts. It is idle-quiet: all bus outputs are zero when it does not own the bus, so they can be OR-merged with the CPU port.

---
 rtl/localbus_dma_if.sv | 19 +
 rtl/localbus_dma.sv | 114 +++++++++++
 2 files changed

// File: rtl/localbus_dma_if.sv
// localbus_dma_if: LocalBus initiator signal set plus arbiter request/grant
interface localbus_dma_if #(
  parameter int XLEN = 32
);
  logic bus_req;
  logic bus_gnt;
  logic [XLEN-1:0] m_addr;
  logic [XLEN-1:0] m_wdata;
  logic [2:0] m_we;
  logic [XLEN-1:0] m_rdata;
  modport master (
    output bus_req, m_addr, m_wdata, m_we,
    input bus_gnt, m_rdata
  );
  modport slave (
    input bus_req, m_addr, m_wdata, m_we,
    output bus_gnt, m_rdata
  );
endinterface

// File: rtl/localbus_dma.sv
// localbus_dma: LocalBus word-copy DMA initiator; define DMA_FILL_EN for pattern-fill mode
module localbus_dma #(
  parameter int XLEN = 32,
  parameter int LWIDTH = 16,
  parameter int RD_LAT = 1,
  parameter logic [2:0] WE_WORD = 3'b111
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic abort,
  input logic [XLEN-1:0] src,
  input logic [XLEN-1:0] dst,
  input logic [LWIDTH-1:0] len,
`ifdef DMA_FILL_EN
  input logic [XLEN-1:0] fill_data,
  input logic fill,
`endif
  output logic busy,
  output logic done,
  output logic err,
  localbus_dma_if.master bus
);
  typedef enum logic [2:0] {IDLE, REQ, RD, WAIT, WR, DONE} state_t;
  state_t state;
  logic [XLEN-1:0] cur_src, cur_dst, data_q;
  logic [LWIDTH-1:0] remain;
  logic [2:0] wait_cnt;
  logic abort_q, abort_now, bad_align;
`ifdef DMA_FILL_EN
  logic fill_q;
  assign bad_align = (src[1:0] != 2'b00 && !fill) || dst[1:0] != 2'b00;
`else
  localparam logic fill_q = 1'b0;
  assign bad_align = src[1:0] != 2'b00 || dst[1:0] != 2'b00;
`endif
  assign abort_now = abort_q | abort;
  // Bus outputs decode straight from registers so they are zero whenever the bus is not owned
  assign bus.bus_req = state inside {REQ, RD, WAIT, WR};
  assign bus.m_addr = (state == RD || state == WAIT) ? cur_src : (state == WR) ? cur_dst : '0;
  assign bus.m_wdata = (state == WR) ? data_q : '0;
  assign bus.m_we = (state == WR) ? WE_WORD : 3'b000;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur_src <= '0;
      cur_dst <= '0;
      data_q <= '0;
      remain <= '0;
      wait_cnt <= '0;
      abort_q <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
`ifdef DMA_FILL_EN
      fill_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      if (abort && state != IDLE) abort_q <= 1'b1;
      case (state)
        IDLE: begin
          abort_q <= 1'b0;
          if (start && bad_align) err <= 1'b1;
          else if (start && len == '0) state <= DONE;
          else if (start) begin
            cur_src <= src;
            cur_dst <= dst;
            remain <= len;
            state <= REQ;
`ifdef DMA_FILL_EN
            fill_q <= fill;
            data_q <= fill_data;
`endif
          end
        end
        REQ: begin
          if (bus.bus_gnt && abort_now) begin
            state <= DONE;
            done <= 1'b1;
          end else if (bus.bus_gnt) state <= fill_q ? WR : RD;
        end
        RD: begin
          state <= WAIT;
          wait_cnt <= 3'(RD_LAT - 1);
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            data_q <= bus.m_rdata;
            state <= WR;
          end else wait_cnt <= wait_cnt - 3'd1;
        end
        WR: begin
          cur_src <= cur_src + XLEN'(4);
          cur_dst <= cur_dst + XLEN'(4);
          remain <= remain - LWIDTH'(1);
          if (remain == LWIDTH'(1) || abort_now) begin
            state <= DONE;
            done <= 1'b1;
          end else if (bus.bus_gnt) state <= fill_q ? WR : RD;
          else state <= REQ;
        end
        DONE: begin
          // A zero-length start arrives without done set and spends one extra cycle here
          abort_q <= 1'b0;
          if (done) state <= IDLE;
          else done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
